// File: rtl/prbs23_chk.sv
// prbs23_chk: self-synchronising x^23+x^18+1 (XNOR) PRBS checker with lock FSM and BER statistics.
// Optional macro PRBS23_CHK_LOSS_CNT_EN adds olos_cnt, a saturating count of lock losses.
module prbs23_chk #(
    parameter int pDAT_W      = 1,
    parameter bit pMSB_FIRST  = 0,
    parameter int pLOCK_CNT   = 16,
    parameter int pWIN        = 64,
    parameter int pUNLOCK_ERR = 8,
    parameter int pCNT_W      = 32
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          iclkena,
    input  logic                          ival,
    input  logic [pDAT_W-1:0]             idat,
    input  logic                          iclear,
    output logic                          oval,
    output logic                          olock,
    output logic [$clog2(pDAT_W+1)-1:0]   oerr,
    output logic [pCNT_W-1:0]             obit_cnt,
    output logic [pCNT_W-1:0]             oerr_cnt
`ifdef PRBS23_CHK_LOSS_CNT_EN
    ,
    output logic [15:0]                   olos_cnt
`endif
);
    localparam int EW  = $clog2(pDAT_W+1);
    localparam int CLW = $clog2(pLOCK_CNT+1);
    localparam int WW  = $clog2(pWIN+1);
    localparam int UW  = $clog2(pUNLOCK_ERR+1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [22:0]        h_q, h_d, h_n, l_q, l_d, l_n;
    logic [CLW-1:0]     clean_q, clean_d;
    logic [WW-1:0]      win_q, win_d;
    logic [UW-1:0]      ew_q, ew_d, ew_inc;
    logic               val_q, val_d;
    logic [EW-1:0]      err_q, err_d, nerr;
    logic [pCNT_W-1:0]  bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
    logic               lock_hit, unlock_hit, win_wrap, cnt_on;
`ifdef PRBS23_CHK_LOSS_CNT_EN
    logic [15:0]        los_q, los_d;
    assign olos_cnt = los_q;
`endif

    function automatic logic [pCNT_W-1:0] sat_add(input logic [pCNT_W-1:0] a, input logic [pCNT_W-1:0] b);
        logic [pCNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[pCNT_W] ? '1 : s[pCNT_W-1:0];
    endfunction

    // Bits are consumed in time order; LOCKED predicts from the free-running replica, SEARCH from history.
    always_comb begin
        logic rx, p;
        h_n  = h_q;
        l_n  = l_q;
        nerr = '0;
        for (int i = 0; i < pDAT_W; i++) begin
            rx   = idat[pMSB_FIRST ? pDAT_W-1-i : i];
            p    = (state_q == LOCKED) ? (l_n[22] ^ l_n[17] ^ 1'b1) : (h_n[22] ^ h_n[17] ^ 1'b1);
            nerr = nerr + EW'(rx != p);
            h_n  = {h_n[21:0], rx};
            l_n  = {l_n[21:0], p};
        end
    end

    always_comb begin
        ew_inc     = ew_q + UW'(nerr != '0);
        lock_hit   = state_q == SEARCH && nerr == '0 && clean_q == CLW'(pLOCK_CNT-1);
        unlock_hit = state_q == LOCKED && ew_inc == UW'(pUNLOCK_ERR);
        win_wrap   = win_q == WW'(pWIN-1);
        cnt_on     = ival && state_q == LOCKED;
    end

    always_ff @(posedge iclk or posedge irst)
        if (irst)
            state_q <= SEARCH;
        else if (iclkena)
            state_q <= state_d;

    always_comb
        state_d = !ival ? state_q : lock_hit ? LOCKED : unlock_hit ? SEARCH : state_q;

    always_comb
        olock = state_q == LOCKED;

    always_comb begin
        h_d       = ival ? h_n : h_q;
        l_d       = !ival ? l_q : state_q == LOCKED ? l_n : lock_hit ? h_n : l_q;
        clean_d   = !ival ? clean_q : (state_q == SEARCH && nerr == '0 && !lock_hit) ? clean_q + CLW'(1) : '0;
        win_d     = (!ival || state_q == SEARCH) ? win_q : (unlock_hit || win_wrap) ? '0 : win_q + WW'(1);
        ew_d      = (!ival || state_q == SEARCH) ? ew_q : (unlock_hit || win_wrap) ? '0 : ew_inc;
        val_d     = ival;
        err_d     = ival ? nerr : err_q;
        bit_cnt_d = iclear ? '0 : cnt_on ? sat_add(bit_cnt_q, pCNT_W'(pDAT_W)) : bit_cnt_q;
        err_cnt_d = iclear ? '0 : cnt_on ? sat_add(err_cnt_q, pCNT_W'(nerr)) : err_cnt_q;
`ifdef PRBS23_CHK_LOSS_CNT_EN
        los_d     = iclear ? '0 : (ival && unlock_hit && los_q != '1) ? los_q + 16'd1 : los_q;
`endif
    end

    always_ff @(posedge iclk or posedge irst)
        if (irst) begin
            h_q       <= '0;
            l_q       <= '0;
            clean_q   <= '0;
            win_q     <= '0;
            ew_q      <= '0;
            val_q     <= 1'b0;
            err_q     <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
`ifdef PRBS23_CHK_LOSS_CNT_EN
            los_q     <= '0;
`endif
        end else if (iclkena) begin
            h_q       <= h_d;
            l_q       <= l_d;
            clean_q   <= clean_d;
            win_q     <= win_d;
            ew_q      <= ew_d;
            val_q     <= val_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
`ifdef PRBS23_CHK_LOSS_CNT_EN
            los_q     <= los_d;
`endif
        end

    assign oval     = val_q;
    assign oerr     = err_q;
    assign obit_cnt = bit_cnt_q;
    assign oerr_cnt = err_cnt_q;
endmodule
